// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared constants for the instruction-side SRAM-to-AXI read bridge.
package inst_sram_axi_rd_bridge_pkg;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;
  localparam logic [3:0] InstArid     = 4'h0;

  // SRAM size is log2(bytes), which is exactly AXI's arsize encoding.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// Fetch-side SRAM-like responder that turns reads into single-beat AXI reads
// and returns the data in acceptance order.
module inst_sram_axi_rd_bridge
  import inst_sram_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter logic [3:0]  ARID        = InstArid
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [1:0]  outst_cnt,
  output logic        resp_err
);

  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [1:0]  size_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        resp_err_q;
  logic        addr_ok;
  logic        r_hs;

  // Write-side and single-beat/ID inputs carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  // Acceptance looks at the registered count, so a return in the same cycle
  // does not free a slot until the next cycle.
  assign addr_ok = inst_sram_req & ~inst_sram_wr & (~arvalid_q | arready) &
                   (32'(cnt_q) < OUTSTANDING);
  assign rready  = (cnt_q != 2'd0);
  assign r_hs    = rvalid & rready;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({addr_ok, r_hs})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arvalid_q  <= 1'b0;
      araddr_q   <= 32'h0;
      size_q     <= 2'b00;
      cnt_q      <= 2'd0;
      data_ok_q  <= 1'b0;
      rdata_q    <= 32'h0;
      resp_err_q <= 1'b0;
    end else begin
      if (addr_ok) begin
        arvalid_q <= 1'b1;
        araddr_q  <= inst_sram_addr;
        size_q    <= inst_sram_size;
      end else if (arready) begin
        arvalid_q <= 1'b0;
      end
      cnt_q     <= cnt_d;
      data_ok_q <= r_hs;
      if (r_hs) begin
        rdata_q <= rdata;
        if (rresp != AxiRespOkay) resp_err_q <= 1'b1;
      end
    end
  end

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign arid              = ARID;
  assign araddr            = araddr_q;
  assign arlen             = 8'd0;
  assign arsize            = axi_size(size_q);
  assign arburst           = AxiBurstIncr;
  assign arlock            = 2'b00;
  assign arcache           = 4'h0;
  assign arprot            = 3'b000;
  assign arvalid           = arvalid_q;
  assign outst_cnt         = cnt_q;
  assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Directed bench for the instruction SRAM-to-AXI read bridge.
module tb_inst_sram_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [1:0]  outst_cnt;
  logic        resp_err;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_sram_axi_rd_bridge #(.OUTSTANDING(2), .ARID(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .outst_cnt(outst_cnt), .resp_err(resp_err)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0; arready = 1; rid = 0; rdata = 0;
    rresp = 0; rlast = 1; rvalid = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    #12;
    n_cmp++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b want 0", arvalid); end
    n_cmp++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr got %h want 0", araddr); end
    n_cmp++; if (arsize !== 3'b000) begin n_fail++; $display("FAIL rst_arsize got %b want 000", arsize); end
    n_cmp++; if (inst_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_ok got %b want 0", inst_sram_data_ok); end
    n_cmp++; if (inst_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", inst_sram_rdata); end
    n_cmp++; if (outst_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", outst_cnt); end
    n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    n_cmp++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready got %b want 0", rready); end
    n_cmp++; if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'h0, 8'h0, 2'b01, 2'b00, 4'h0, 3'b000})
      begin n_fail++; $display("FAIL ar_const got %h/%h/%b/%b/%h/%b", arid, arlen, arburst, arlock, arcache, arprot); end
    #10 resetn = 1;
    step();
  endtask

  task automatic test_single_read(input logic [31:0] addr, input logic [31:0] data);
    inst_sram_req = 1; inst_sram_addr = addr; inst_sram_size = 2'd2; arready = 1;
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL sr_addr_ok got %b want 1", inst_sram_addr_ok); end
    step(); // T+1
    inst_sram_req = 0;
    #1;
    n_cmp++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL sr_arvalid got %b want 1", arvalid); end
    n_cmp++; if (araddr !== addr) begin n_fail++; $display("FAIL sr_araddr got %h want %h", araddr, addr); end
    n_cmp++; if (arsize !== 3'b010) begin n_fail++; $display("FAIL sr_arsize got %b want 010", arsize); end
    n_cmp++; if (outst_cnt !== 2'd1) begin n_fail++; $display("FAIL sr_cnt1 got %0d want 1", outst_cnt); end
    step(); // T+2
    rvalid = 1; rdata = data;
    #1;
    n_cmp++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL sr_arvalid_drop got %b want 0", arvalid); end
    n_cmp++; if (inst_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL sr_early_data_ok got %b want 0", inst_sram_data_ok); end
    step(); // T+3
    rvalid = 0; rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (inst_sram_data_ok !== 1'b1) begin n_fail++; $display("FAIL sr_data_ok got %b want 1", inst_sram_data_ok); end
    n_cmp++; if (inst_sram_rdata !== data) begin n_fail++; $display("FAIL sr_rdata got %h want %h", inst_sram_rdata, data); end
    n_cmp++; if (outst_cnt !== 2'd0) begin n_fail++; $display("FAIL sr_cnt0 got %0d want 0", outst_cnt); end
    step();
    n_cmp++; if (inst_sram_data_ok !== 1'b0) begin n_fail++; $display("FAIL sr_pulse got %b want 0", inst_sram_data_ok); end
    n_cmp++; if (inst_sram_rdata !== data) begin n_fail++; $display("FAIL sr_rdata_hold got %h want %h", inst_sram_rdata, data); end
  endtask

  task automatic test_ar_backpressure();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; arready = 0;
    step();
    inst_sram_addr = 32'h1C00_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000)
        begin n_fail++; $display("FAIL bp_hold%0d got %b/%h want 1/1c000000", i, arvalid, araddr); end
      n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d got %b want 0", i, inst_sram_addr_ok); end
      step();
    end
    arready = 1;
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept got %b want 1", inst_sram_addr_ok); end
    step();
    inst_sram_req = 0;
    #1;
    n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h1C00_0004)
      begin n_fail++; $display("FAIL bp_ar2 got %b/%h want 1/1c000004", arvalid, araddr); end
    n_cmp++; if (outst_cnt !== 2'd2) begin n_fail++; $display("FAIL bp_cnt got %0d want 2", outst_cnt); end
    step();
    rvalid = 1; rdata = 32'hB000_0000;
    step();
    rdata = 32'hB000_0004;
    #1;
    n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hB000_0000)
      begin n_fail++; $display("FAIL bp_r1 got %b/%h want 1/b0000000", inst_sram_data_ok, inst_sram_rdata); end
    step();
    rvalid = 0;
    #1;
    n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hB000_0004)
      begin n_fail++; $display("FAIL bp_r2 got %b/%h want 1/b0000004", inst_sram_data_ok, inst_sram_rdata); end
    n_cmp++; if (outst_cnt !== 2'd0) begin n_fail++; $display("FAIL bp_drain got %0d want 0", outst_cnt); end
    step();
  endtask

  task automatic test_outstanding_limit();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA000_0000; exp_data[1] = 32'hA000_0004; exp_data[2] = 32'hA000_0008;
    arready = 1; inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ol_acc1 got %b want 1", inst_sram_addr_ok); end
    step();
    inst_sram_addr = 32'h1C00_0004;
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ol_acc2 got %b want 1", inst_sram_addr_ok); end
    step();
    inst_sram_addr = 32'h1C00_0008;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL ol_block%0d got %b want 0", i, inst_sram_addr_ok); end
      n_cmp++; if (outst_cnt !== 2'd2) begin n_fail++; $display("FAIL ol_cnt%0d got %0d want 2", i, outst_cnt); end
      step();
    end
    rvalid = 1; rdata = exp_data[0];
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b0) begin n_fail++; $display("FAIL ol_same_cycle got %b want 0", inst_sram_addr_ok); end
    step();
    rvalid = 0;
    #1;
    n_cmp++; if (inst_sram_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ol_acc3 got %b want 1", inst_sram_addr_ok); end
    n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== exp_data[0])
      begin n_fail++; $display("FAIL ol_r0 got %b/%h want 1/%h", inst_sram_data_ok, inst_sram_rdata, exp_data[0]); end
    step();
    inst_sram_req = 0;
    #1;
    n_cmp++; if (araddr !== 32'h1C00_0008) begin n_fail++; $display("FAIL ol_ar3 got %h want 1c000008", araddr); end
    step();
    for (int i = 1; i < 3; i++) begin
      rvalid = 1; rdata = exp_data[i];
      step();
      rvalid = 0;
      #1;
      n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== exp_data[i])
        begin n_fail++; $display("FAIL ol_r%0d got %b/%h want 1/%h", i, inst_sram_data_ok, inst_sram_rdata, exp_data[i]); end
    end
    n_cmp++; if (outst_cnt !== 2'd0) begin n_fail++; $display("FAIL ol_drain got %0d want 0", outst_cnt); end
    step();
  endtask

  task automatic test_write_reject();
    inst_sram_req = 1; inst_sram_wr = 1; inst_sram_wstrb = 4'hF;
    inst_sram_addr = 32'h1C00_0100; inst_sram_wdata = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (inst_sram_addr_ok !== 1'b0 || arvalid !== 1'b0)
        begin n_fail++; $display("FAIL wr_reject%0d got addr_ok=%b arvalid=%b want 0/0", i, inst_sram_addr_ok, arvalid); end
      step();
    end
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_wstrb = 0;
    step();
  endtask

  task automatic test_error_resp();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0200; arready = 1;
    step();
    inst_sram_req = 0;
    step();
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    step();
    rvalid = 0; rresp = 2'b00;
    #1;
    n_cmp++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL er_data got %b/%h want 1/deadbeef", inst_sram_data_ok, inst_sram_rdata); end
    n_cmp++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL er_set got %b want 1", resp_err); end
    step();
    test_single_read(32'h1C00_0204, 32'h0000_1111);
    n_cmp++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL er_sticky got %b want 1", resp_err); end
  endtask

  task automatic test_async_reset();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0300; arready = 0;
    step();
    inst_sram_req = 0;
    #1;
    n_cmp++; if (arvalid !== 1'b1 || outst_cnt !== 2'd1)
      begin n_fail++; $display("FAIL ar_pre got %b/%0d want 1/1", arvalid, outst_cnt); end
    #1 resetn = 0;
    #1;
    n_cmp++; if (arvalid !== 1'b0 || outst_cnt !== 2'd0 || inst_sram_data_ok !== 1'b0)
      begin n_fail++; $display("FAIL ar_async got %b/%0d/%b want 0/0/0", arvalid, outst_cnt, inst_sram_data_ok); end
    n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL ar_err_clr got %b want 0", resp_err); end
    idle_inputs();
    step();
    @(negedge clk) resetn = 1;
    step();
    test_single_read(32'h1C00_0000, 32'h0280_0000);
  endtask

  initial begin
    test_reset();
    test_single_read(32'h1C00_0000, 32'h0280_0000);
    test_ar_backpressure();
    test_outstanding_limit();
    test_write_reject();
    test_error_resp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
- Responder end of the instruction-side SRAM-like interface (req / addr_ok / data_ok) driven by the fetch stage.
- Accepts read requests, issues single-beat AXI read-address transactions, sinks AXI read data, and returns it in order as data_ok/rdata.
- Sits between the fetch stage and the top-level AXI crossbar.
- Read-only: write requests are never acknowledged.

Parameters:
- OUTSTANDING, 2, max accepted-but-unreturned reads (1..3).
- ARID, 4'h0, fixed AXI ID driven on arid; rid is not checked.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous assert, active-low
- inst_sram_req  in  1  request valid
- inst_sram_wr  in  1  write flag; 1 = write (rejected)
- inst_sram_size  in  2  bytes = 2^size
- inst_sram_wstrb  in  4  unused
- inst_sram_addr  in  32  request address
- inst_sram_wdata  in  32  unused
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- arid  out  4  AXI read ID (= ARID)
- araddr  out  32  AXI read address
- arlen  out  8  always 0
- arsize  out  3  {1'b0, latched size}
- arburst  out  2  always 2'b01
- arlock  out  2  always 0
- arcache  out  4  always 0
- arprot  out  3  always 0
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rid  in  4  ignored
- rdata  in  32  AXI read data
- rresp  in  2  AXI response
- rlast  in  1  ignored (single beat)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- outst_cnt  out  2  current outstanding count
- resp_err  out  1  sticky; set when any rresp != 0

Behaviour:
- Reset (resetn=0, asynchronous):
  - arvalid, araddr, arsize-size, data_ok, rdata, outst_cnt, resp_err all 0.
  - Takes effect immediately, even mid-transaction. Any in-flight AXI beats are lost; the fetch stage is also in reset.
- Accept rule (combinational):
  - addr_ok = req & ~wr & (~arvalid | arready) & (outst_cnt < OUTSTANDING).
  - addr_ok is never asserted when wr = 1.
- AR register:
  - On addr_ok: araddr <= addr, size latched, arvalid <= 1.
  - Else if arready: arvalid <= 0.
  - araddr and arsize are held stable while arvalid & ~arready (AXI rule).
  - Back-to-back: a new request may be accepted in the same cycle the previous AR handshakes.
- Outstanding counter:
  - +1 on addr_ok; -1 on (rvalid & rready).
  - Both in the same cycle: unchanged.
  - Never exceeds OUTSTANDING; never underflows.
- R channel:
  - rready = (outst_cnt != 0).
  - On rvalid & rready, next cycle: data_ok = 1 and inst_sram_rdata = rdata. data_ok is a one-cycle pulse per beat.
  - rdata holds its value until the next beat.
  - Return order equals acceptance order (single ID, AXI in-order).
- resp_err set on a handshake with rresp != 0; cleared only by reset. Data is still returned.
- Latency:
  - addr_ok at cycle T; arvalid at T+1.
  - With arready at T+1 and rvalid at T+2, data_ok occurs at T+3.
  - Minimum request-to-data is 3 cycles.
- Simultaneous events:
  - addr_ok together with an R handshake at full count is not allowed: acceptance checks the registered count, so it stalls one cycle.
- wr = 1 with req = 1: addr_ok stays 0 indefinitely; no AR is issued.
- Aligned-address checking is not done here (ADEF is raised upstream).

Decomposition:
- Shared header mycpu.h gains: AXI_BURST_INCR (2'b01), AXI_RESP_OKAY (2'b00), and INST_ARID (4'h0) as defaults.
- No sub-module: the AR register and outstanding counter are small enough to stay inline.

Test Plan:
- Single read: req addr=0x1C000000, size=2; arready=1; rvalid 1 cycle later with rdata=0x02800000 -> addr_ok at T, araddr=0x1C000000 and arsize=3'b010 at T+1, data_ok=1 with rdata=0x02800000 at T+3, outst_cnt returns to 0.
- AR backpressure: arready=0 for 4 cycles after accept -> araddr/arvalid stable, second req with addr 0x1C000004 gets addr_ok=0 until the cycle arready=1, then is accepted the same cycle.
- Outstanding limit: 3 requests with R withheld -> first 2 accepted, third addr_ok=0, outst_cnt=2. Release one R -> third accepted the cycle after that R handshake. Data returns in order 0x...00, 0x...04, 0x...08.
- Write rejection: req=1 wr=1 wstrb=4'hF for 10 cycles -> addr_ok=0, arvalid=0 throughout.
- Error response: rresp=2'b10 on a beat -> data_ok still pulses with data; resp_err=1 and stays 1 across later OKAY beats.
- Async reset mid-flight: deassert resetn between cycles while arvalid=1, outst_cnt=1 -> arvalid, outst_cnt, data_ok drop to 0 without a clock edge; after release, a new request behaves as in the single-read case.
